// File: rtl/riscv_pkg.sv
// Shared RV32 front-end types and constants.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched words with their PCs; flush beats push and pop.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  fetch_entry_t                  din,
    output fetch_entry_t                  head,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        head  = mem_q[rd_ptr_q];
        count = count_q;
        empty = (count_q == '0);
    end

    // Upstream credit accounting guarantees a free slot for every push.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: credit-limited word requests, in-order responses buffered
// in a small FIFO toward decode, with redirect flushing buffered and in-flight fetches.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    fetch_entry_t    fifo_din;
    fetch_entry_t    fifo_head;

    logic [CW-1:0]   in_use;
    logic            has_credit;
    logic            req_fire;
    logic [XLEN-1:0] redirect_base;

    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        rsp_pc_d       = rsp_pc_q;
        drop_d         = drop_q;
        fifo_push      = 1'b0;
        fifo_din.pc    = rsp_pc_q;
        fifo_din.instr = imem_rsp_data;
        redirect_base  = redirect_pc & ~32'd3;

        // Stale in-flight words still hold memory slots, so outstanding is also capped
        // at its counter range to keep drop exact across repeated redirects.
        in_use         = fifo_count + (outstanding_q - drop_q);
        has_credit     = (in_use < CW'(DEPTH)) && (outstanding_q != CNT_MAX);
        imem_req_valid = has_credit && !redirect_valid && !rst;
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        outstanding_d  = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (redirect_valid) begin
            fetch_pc_d = redirect_base;
            rsp_pc_d   = redirect_base;
            drop_d     = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    fifo_push = 1'b1;
                    rsp_pc_d  = rsp_pc_q + PC_STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .din   (fifo_din),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_comb begin
        instr_valid = !fifo_empty;
        fifo_pop    = instr_valid && instr_ready;
        instr       = fifo_empty ? '0 : fifo_head.instr;
        instr_pc    = fifo_empty ? '0 : fifo_head.pc;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against an in-order memory model and a PC-stream reference.
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] acc_addr_log[$];
    int          acc_cyc_log[$];
    logic [31:0] dlv_pc_log[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat_lo = 1, lat_hi = 1, req_rdy_pct = 100, dec_rdy_pct = 100;
    int live = 0, n_acc = 0, n_dlv = 0, iv_cyc = -1;
    logic        redir_now = 1'b0, redir_on_rsp = 1'b0, redir_hit = 1'b0;
    logic [31:0] redir_tgt = '0;
    logic [31:0] exp_fetch_pc, exp_dlv_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        acc_addr_log.delete();
        acc_cyc_log.delete();
        dlv_pc_log.delete();
        iv_cyc = -1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        mq.delete();
        exp_fetch_pc = RESET_PC;
        exp_dlv_pc   = RESET_PC;
        live         = 0;
        redir_now    = 1'b0;
        redir_on_rsp = 1'b0;
    endtask

    // One clock: drive inputs on the falling edge, observe and score just after.
    task automatic step();
        logic  rsp_now;
        logic  did_redir;
        mreq_t m;
        @(negedge clk);
        rsp_now        = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(mq[0].addr) : 32'hDEAD_BEEF;
        imem_req_ready = ($urandom_range(99) < req_rdy_pct);
        instr_ready    = ($urandom_range(99) < dec_rdy_pct);
        did_redir      = redir_now || (redir_on_rsp && rsp_now && instr_valid);
        if (redir_on_rsp && did_redir) begin
            instr_ready  = 1'b1;
            redir_on_rsp = 1'b0;
            redir_hit    = 1'b1;
        end
        redirect_valid = did_redir;
        redirect_pc    = redir_tgt;
        redir_now      = 1'b0;
        #1;
        if (rsp_now) void'(mq.pop_front());
        if (instr_valid && iv_cyc < 0) iv_cyc = cyc;
        if (!instr_valid) begin
            check("idle_instr", instr, 32'd0);
            check("idle_instr_pc", instr_pc, 32'd0);
        end
        if (did_redir) begin
            check("redir_req_valid", 32'(imem_req_valid), 32'd0);
            exp_fetch_pc = redir_tgt & ~32'd3;
            exp_dlv_pc   = redir_tgt & ~32'd3;
            live         = 0;
        end else begin
            if (instr_valid && instr_ready) begin
                check("dlv_pc", instr_pc, exp_dlv_pc);
                check("dlv_instr", instr, mem_word(exp_dlv_pc));
                dlv_pc_log.push_back(instr_pc);
                exp_dlv_pc += 32'd4;
                live--;
                n_dlv++;
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_fetch_pc);
                m.addr = imem_req_addr;
                m.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
                mq.push_back(m);
                acc_addr_log.push_back(imem_req_addr);
                acc_cyc_log.push_back(cyc);
                exp_fetch_pc += 32'd4;
                live++;
                n_acc++;
                check("credit_bound", 32'(live > DEPTH), 32'd0);
            end
        end
        cyc++;
    endtask

    task automatic run_until_acc(input int target, input int budget, input string tag);
        int b = 0;
        while (n_acc < target && b < budget) begin
            step();
            b++;
        end
        check(tag, 32'(n_acc >= target), 32'd1);
    endtask

    task automatic run_until_dlv(input int target, input int budget, input string tag);
        int b = 0;
        while (n_dlv < target && b < budget) begin
            step();
            b++;
        end
        check(tag, 32'(n_dlv >= target), 32'd1);
    endtask

    task automatic set_env(input int lo, input int hi, input int rq, input int dc);
        lat_lo = lo; lat_hi = hi; req_rdy_pct = rq; dec_rdy_pct = dc;
    endtask

    initial begin
        int a0;
        int d0;

        // Sequential fetch after reset, latency 1.
        do_reset();
        set_env(1, 1, 100, 100);
        clear_logs();
        a0 = n_acc; d0 = n_dlv;
        run_until_dlv(d0 + 3, 30, "t1_progress");
        check("t1_acc0", acc_addr_log[0], 32'h0);
        check("t1_acc1", acc_addr_log[1], 32'h4);
        check("t1_acc2", acc_addr_log[2], 32'h8);
        check("t1_dlv0", dlv_pc_log[0], 32'h0);
        check("t1_dlv2", dlv_pc_log[2], 32'h8);
        check("t1_iv_latency", 32'(iv_cyc - acc_cyc_log[0]), 32'd2);

        // Decode stalled: credit limits fetch to DEPTH, one pop frees one request.
        do_reset();
        set_env(1, 1, 100, 0);
        a0 = n_acc;
        repeat (12) step();
        check("t2_acc_stalled", 32'(n_acc - a0), 32'(DEPTH));
        check("t2_req_valid_off", 32'(imem_req_valid), 32'd0);
        dec_rdy_pct = 100;
        d0 = n_dlv;
        step();
        check("t2_one_pop", 32'(n_dlv - d0), 32'd1);
        dec_rdy_pct = 0;
        clear_logs();
        a0 = n_acc;
        repeat (12) step();
        check("t2_acc_after_pop", 32'(n_acc - a0), 32'd1);
        check("t2_next_addr", acc_addr_log[0], 32'h8);

        // Memory not ready: request held steady.
        do_reset();
        set_env(1, 1, 0, 100);
        a0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_req_valid", 32'(imem_req_valid), 32'd1);
            check("t3_req_addr", imem_req_addr, 32'h0);
            check("t3_instr_valid", 32'(instr_valid), 32'd0);
        end
        check("t3_no_accept", 32'(n_acc - a0), 32'd0);

        // Redirect with two requests in flight.
        do_reset();
        set_env(5, 5, 100, 100);
        a0 = n_acc;
        run_until_acc(a0 + 2, 10, "t4_two_inflight");
        redir_tgt = 32'h0000_0103;
        redir_now = 1'b1;
        step();
        set_env(1, 1, 100, 100);
        clear_logs();
        d0 = n_dlv;
        run_until_dlv(d0 + 3, 40, "t4_progress");
        check("t4_first_req", acc_addr_log[0], 32'h100);
        check("t4_first_dlv", dlv_pc_log[0], 32'h100);

        // Redirect coinciding with a response and a pop.
        do_reset();
        set_env(2, 2, 100, 0);
        redir_tgt    = 32'h0000_0400;
        redir_hit    = 1'b0;
        redir_on_rsp = 1'b1;
        for (int i = 0; i < 20 && !redir_hit; i++) step();
        check("t5_redir_hit", 32'(redir_hit), 32'd1);
        redir_on_rsp = 1'b0;
        set_env(1, 1, 100, 100);
        clear_logs();
        d0 = n_dlv;
        run_until_dlv(d0 + 2, 40, "t5_progress");
        check("t5_dlv0", dlv_pc_log[0], 32'h400);
        check("t5_dlv1", dlv_pc_log[1], 32'h404);

        // PC wrap, then asynchronous reset mid-burst.
        do_reset();
        set_env(1, 1, 100, 100);
        redir_tgt = 32'hFFFF_FFF8;
        redir_now = 1'b1;
        step();
        clear_logs();
        a0 = n_acc;
        run_until_acc(a0 + 3, 20, "t6_wrap_progress");
        check("t6_acc0", acc_addr_log[0], 32'hFFFF_FFF8);
        check("t6_acc1", acc_addr_log[1], 32'hFFFF_FFFC);
        check("t6_acc2", acc_addr_log[2], 32'h0000_0000);
        repeat (3) step();
        @(posedge clk);
        #2;
        do_reset();
        set_env(1, 1, 100, 100);
        clear_logs();
        a0 = n_acc; d0 = n_dlv;
        run_until_acc(a0 + 1, 10, "t6_post_rst_acc");
        check("t6_post_rst_addr", acc_addr_log[0], RESET_PC);
        run_until_dlv(d0 + 1, 20, "t6_post_rst_dlv");
        check("t6_post_rst_pc", dlv_pc_log[0], RESET_PC);

        // Randomized traffic with redirects and occasional resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                lat_lo      = int'($urandom_range(4, 1));
                lat_hi      = lat_lo + int'($urandom_range(3, 0));
                req_rdy_pct = int'($urandom_range(100, 30));
                dec_rdy_pct = int'($urandom_range(100, 30));
            end
            if (i % 1000 == 999) begin
                do_reset();
            end
            redir_now = ($urandom_range(99) < 3);
            redir_tgt = $urandom;
            step();
        end
        set_env(1, 1, 100, 100);
        d0 = n_dlv;
        run_until_dlv(d0 + 8, 100, "rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
